// File: rtl/tri_pkg.sv
// rtl/tri_pkg.sv - shared state encodings and parameter defaults for the triangle scan scheduler
package tri_pkg;

  localparam int CW_DEF      = 3;
  localparam int MAX_OUT_DEF = 4;
  localparam int HCW_DEF     = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BBOX  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/tri_bbox.sv
// rtl/tri_bbox.sv - combinational unsigned min/max of three coordinates
module tri_bbox
  import tri_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic [CW-1:0] c,
  output logic [CW-1:0] min_o,
  output logic [CW-1:0] max_o
);

  logic [CW-1:0] min_ab;
  logic [CW-1:0] max_ab;

  always_comb begin
    min_ab = (a < b) ? a : b;
    max_ab = (a > b) ? a : b;
    min_o  = (min_ab < c) ? min_ab : c;
    max_o  = (max_ab > c) ? max_ab : c;
  end

endmodule

// File: rtl/tri_scan_sched.sv
// rtl/tri_scan_sched.sv - loads three vertices, walks their bounding box row-major
// into the inside-test PE with a cap on requests in flight, and counts hits
module tri_scan_sched
  import tri_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int HCW     = HCW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           nt,
  input  logic [CW-1:0]  xi,
  input  logic [CW-1:0]  yi,
  output logic           busy,
  output logic           cand_valid,
  input  logic           cand_ready,
  output logic [CW-1:0]  cand_x,
  output logic [CW-1:0]  cand_y,
  input  logic           pe_ret_valid,
  input  logic           pe_ret_hit,
  output logic [HCW-1:0] hit_cnt,
  output logic           done
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] MAX_OUT_W = OW'(MAX_OUT);

  state_e state_q, state_d;
  logic [1:0]     load_cnt_q, load_cnt_d;
  logic [CW-1:0]  v0x_q, v0y_q, v1x_q, v1y_q, v2x_q, v2y_q;
  logic [CW-1:0]  v0x_d, v0y_d, v1x_d, v1y_d, v2x_d, v2y_d;
  logic [CW-1:0]  xmin_q, xmax_q, ymin_q, ymax_q;
  logic [CW-1:0]  xmin_d, xmax_d, ymin_d, ymax_d;
  logic [CW-1:0]  cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [OW-1:0]  out_q, out_d;
  logic [HCW-1:0] hit_q, hit_d;

  logic [CW-1:0]  bx_min, bx_max, by_min, by_max;
  logic           issue, ret_ok, last_issue, counting;

  tri_bbox #(.CW(CW)) u_bbox_x (
    .a(v0x_q), .b(v1x_q), .c(v2x_q), .min_o(bx_min), .max_o(bx_max)
  );

  tri_bbox #(.CW(CW)) u_bbox_y (
    .a(v0y_q), .b(v1y_q), .c(v2y_q), .min_o(by_min), .max_o(by_max)
  );

  // Returns outside SCAN/DRAIN or with nothing in flight are stray and dropped.
  always_comb begin
    counting   = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    issue      = cand_valid && cand_ready;
    ret_ok     = pe_ret_valid && counting && (out_q != '0);
    last_issue = issue && (cand_x_q == xmax_q) && (cand_y_q == ymax_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (nt) state_d = ST_LOAD;
      ST_LOAD:  if (load_cnt_q == 2'd1) state_d = ST_BBOX;
      ST_BBOX:  state_d = ST_SCAN;
      ST_SCAN:  if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if ((out_q == '0) || ((out_q == OW'(1)) && ret_ok)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    cand_valid = (state_q == ST_SCAN) && (out_q < MAX_OUT_W);
    done       = (state_q == ST_DONE);
  end

  always_comb begin
    load_cnt_d = load_cnt_q;
    v0x_d = v0x_q;  v0y_d = v0y_q;
    v1x_d = v1x_q;  v1y_d = v1y_q;
    v2x_d = v2x_q;  v2y_d = v2y_q;
    xmin_d = xmin_q;  xmax_d = xmax_q;
    ymin_d = ymin_q;  ymax_d = ymax_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    out_d    = out_q;
    hit_d    = hit_q;

    case (state_q)
      ST_IDLE: if (nt) begin
        v0x_d      = xi;
        v0y_d      = yi;
        load_cnt_d = 2'd0;
        hit_d      = '0;
      end
      ST_LOAD: begin
        if (load_cnt_q == 2'd0) begin
          v1x_d = xi;  v1y_d = yi;
        end else begin
          v2x_d = xi;  v2y_d = yi;
        end
        load_cnt_d = load_cnt_q + 2'd1;
      end
      ST_BBOX: begin
        xmin_d   = bx_min;  xmax_d = bx_max;
        ymin_d   = by_min;  ymax_d = by_max;
        cand_x_d = bx_min;
        cand_y_d = by_min;
      end
      ST_SCAN: if (issue) begin
        if (cand_x_q != xmax_q) begin
          cand_x_d = cand_x_q + CW'(1);
        end else begin
          cand_x_d = xmin_q;
          cand_y_d = cand_y_q + CW'(1);
        end
      end
      default: ;
    endcase

    if (issue && !ret_ok)      out_d = out_q + OW'(1);
    else if (!issue && ret_ok) out_d = out_q - OW'(1);

    if (ret_ok && pe_ret_hit) hit_d = hit_q + HCW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_q <= '0;
      v0x_q <= '0;  v0y_q <= '0;
      v1x_q <= '0;  v1y_q <= '0;
      v2x_q <= '0;  v2y_q <= '0;
      xmin_q <= '0;  xmax_q <= '0;
      ymin_q <= '0;  ymax_q <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      out_q    <= '0;
      hit_q    <= '0;
    end else begin
      load_cnt_q <= load_cnt_d;
      v0x_q <= v0x_d;  v0y_q <= v0y_d;
      v1x_q <= v1x_d;  v1y_q <= v1y_d;
      v2x_q <= v2x_d;  v2y_q <= v2y_d;
      xmin_q <= xmin_d;  xmax_q <= xmax_d;
      ymin_q <= ymin_d;  ymax_q <= ymax_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      out_q    <= out_d;
      hit_q    <= hit_d;
    end
  end

  assign cand_x  = cand_x_q;
  assign cand_y  = cand_y_q;
  assign hit_cnt = hit_q;

endmodule

// File: tb/tb_tri_scan_sched.sv
// tb/tb_tri_scan_sched.sv - table-driven and scoreboard bench for tri_scan_sched
module tb_tri_scan_sched;

  localparam int MAX_OUT = 4;

  logic       clk = 1'b0;
  logic       rst, nt, cand_ready, pe_ret_valid, pe_ret_hit;
  logic [2:0] xi, yi;
  logic       busy, cand_valid, done;
  logic [2:0] cand_x, cand_y;
  logic [6:0] hit_cnt;

  tri_scan_sched dut (
    .clk(clk), .rst(rst), .nt(nt), .xi(xi), .yi(yi), .busy(busy),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_x(cand_x), .cand_y(cand_y),
    .pe_ret_valid(pe_ret_valid), .pe_ret_hit(pe_ret_hit), .hit_cnt(hit_cnt), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v0x; int v0y; int v1x; int v1y; int v2x; int v2y;
    int mode;   // 0 always ready, 1 toggling, 2 random
    int delay;  // PE return latency in cycles
    int spam;   // pulse nt while busy
    int exp_n;
    int exp_hits;
  } test_t;

  typedef struct { int due; int hit; } ret_t;
  typedef struct { int x; int y; } cand_t;

  test_t tests[6];
  ret_t  ret_q[$];
  cand_t exp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, ready_mode, ret_delay, bench_out, model_hits, issues;
  int first_valid, done_cnt, t0;
  bit prev_stall;
  int prev_x, prev_y;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int hit_fn(input int x, input int y);
    return (x + y <= 3) ? 1 : 0;
  endfunction

  // One negedge: drive PE handshake and returns, score issued candidates.
  task automatic step();
    cand_t e;
    @(negedge clk);
    cyc++;
    if (cand_valid && first_valid < 0) first_valid = cyc;
    if (done) done_cnt++;
    if (prev_stall) begin
      chk("hold_valid", int'(cand_valid), 1);
      chk("hold_x", int'(cand_x), prev_x);
      chk("hold_y", int'(cand_y), prev_y);
    end
    if (bench_out >= MAX_OUT) chk("cap_valid_low", int'(cand_valid), 0);
    case (ready_mode)
      0:       cand_ready = 1'b1;
      1:       cand_ready = (cyc % 2 == 0);
      default: cand_ready = 1'($urandom_range(0, 1));
    endcase
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      pe_ret_valid = 1'b1;
      pe_ret_hit   = 1'(ret_q[0].hit);
      model_hits  += ret_q[0].hit;
      void'(ret_q.pop_front());
      bench_out--;
    end else begin
      pe_ret_valid = 1'b0;
      pe_ret_hit   = 1'b1;
    end
    if (cand_valid && cand_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_candidate", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("cand_x", int'(cand_x), e.x);
        chk("cand_y", int'(cand_y), e.y);
      end
      ret_q.push_back('{cyc + ret_delay, hit_fn(int'(cand_x), int'(cand_y))});
      bench_out++;
      issues++;
      chk("outstanding_le_max", int'(bench_out <= MAX_OUT), 1);
    end
    prev_stall = cand_valid && !cand_ready;
    prev_x = int'(cand_x);
    prev_y = int'(cand_y);
  endtask

  task automatic start_tri(input test_t t);
    int xmn, xmx, ymn, ymx;
    ready_mode = t.mode;  ret_delay = t.delay;
    first_valid = -1;  done_cnt = 0;  prev_stall = 0;
    model_hits = 0;  issues = 0;  bench_out = 0;
    ret_q.delete();  exp_q.delete();
    xmn = t.v0x < t.v1x ? t.v0x : t.v1x;  xmn = t.v2x < xmn ? t.v2x : xmn;
    xmx = t.v0x > t.v1x ? t.v0x : t.v1x;  xmx = t.v2x > xmx ? t.v2x : xmx;
    ymn = t.v0y < t.v1y ? t.v0y : t.v1y;  ymn = t.v2y < ymn ? t.v2y : ymn;
    ymx = t.v0y > t.v1y ? t.v0y : t.v1y;  ymx = t.v2y > ymx ? t.v2y : ymx;
    for (int y = ymn; y <= ymx; y++)
      for (int x = xmn; x <= xmx; x++)
        exp_q.push_back('{x, y});
    step();
    nt = 1'b1;  xi = 3'(t.v0x);  yi = 3'(t.v0y);  t0 = cyc;
    step();
    chk("busy_after_nt", int'(busy), 1);
    nt = 1'(t.spam);  xi = 3'(t.v1x);  yi = 3'(t.v1y);
    step();
    xi = 3'(t.v2x);  yi = 3'(t.v2y);
    step();
    nt = 1'(t.spam);  xi = 3'($urandom);  yi = 3'($urandom);
  endtask

  task automatic run_tri(input test_t t);
    bit seen = 0;
    start_tri(t);
    for (int n = 0; n < 300; n++) begin
      step();
      if (done_cnt > 0) begin seen = 1; nt = 1'b0; break; end
      nt = 1'(t.spam != 0 && (cyc % 3 == 0));
      xi = 3'($urandom);  yi = 3'($urandom);
    end
    chk("done_seen", int'(seen), 1);
    if (seen) begin
      chk("hit_cnt_at_done", int'(hit_cnt), t.exp_hits);
      chk("model_hits", model_hits, t.exp_hits);
      chk("issues", issues, t.exp_n);
      chk("cands_left", exp_q.size(), 0);
      chk("returns_left_at_done", ret_q.size(), 0);
      chk("first_valid_latency", first_valid - t0, 4);
      step();
      chk("busy_after_done", int'(busy), 0);
      chk("done_pulse_len", int'(done), 0);
      chk("hit_cnt_hold", int'(hit_cnt), t.exp_hits);
      repeat (3) step();
      chk("done_once", done_cnt, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    tests[0] = '{0,0, 3,0, 0,3, 0, 1, 0, 16, 10};
    tests[1] = '{0,0, 3,0, 0,3, 1, 1, 0, 16, 10};
    tests[2] = '{0,0, 3,0, 0,3, 0, 8, 0, 16, 10};
    tests[3] = '{5,5, 5,5, 5,5, 0, 1, 0, 1, 0};
    tests[4] = '{1,2, 4,1, 2,3, 0, 1, 1, 12, 3};
    tests[5] = '{7,7, 6,7, 7,6, 2, 3, 0, 4, 0};

    rst = 1'b1;  nt = 1'b0;  xi = '0;  yi = '0;
    cand_ready = 1'b0;  pe_ret_valid = 1'b0;  pe_ret_hit = 1'b0;
    ready_mode = 0;  ret_delay = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(cand_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cand_x", int'(cand_x), 0);
    chk("rst_cand_y", int'(cand_y), 0);
    chk("rst_hit_cnt", int'(hit_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_tri(tests[i]);

    // Abort in SCAN after six issues, then stray returns while idle.
    start_tri(tests[0]);
    ok = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (issues >= 6) begin ok = 1; break; end
    end
    chk("reach_six_issues", int'(ok), 1);
    @(negedge clk);
    cand_ready = 1'b0;  pe_ret_valid = 1'b0;  rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(cand_valid), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_cand_x", int'(cand_x), 0);
    chk("abort_cand_y", int'(cand_y), 0);
    chk("abort_hit_cnt", int'(hit_cnt), 0);
    repeat (3) begin
      pe_ret_valid = 1'b1;  pe_ret_hit = 1'b1;
      @(negedge clk);
      pe_ret_valid = 1'b0;
      @(negedge clk);
    end
    chk("stray_hit_cnt", int'(hit_cnt), 0);
    chk("stray_busy", int'(busy), 0);
    chk("stray_done", int'(done), 0);
    ret_q.delete();  exp_q.delete();  bench_out = 0;

    run_tri(tests[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
